// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: two-source round-robin arbiter, FIFO, registered RF write port.
// Optional forwarding lookup of queued/in-flight writes enabled by WB_BYPASS_EN.
module regfile_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Clrn,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [4:0]    alu_rd,
  input  logic [31:0]   alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [4:0]    mem_rd,
  input  logic [31:0]   mem_data,
  input  logic          wb_stall,
  output logic [4:0]    Wr,
  output logic [31:0]   D,
  output logic          We,
  output logic [PW-1:0] pend_cnt,
  input  logic [4:0]    Ra,
  input  logic [4:0]    Rb,
  output logic          Fa,
  output logic          Fb,
  output logic [31:0]   FQa,
  output logic [31:0]   FQb
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [PW-1:0] FULL = PW'(DEPTH);

  logic [4:0]    rd_q  [DEPTH];
  logic [31:0]   dat_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          last_mem_q;
  logic [4:0]    wr_q;
  logic [31:0]   d_q;
  logic          we_q;

  logic          gnt_alu, gnt_mem;
  logic          full, acc, push, pop;
  logic [4:0]    in_rd;
  logic [31:0]   in_data;

  // Tie goes to whichever source did not win the last accepted handshake
  assign gnt_alu = alu_valid & (~mem_valid | last_mem_q);
  assign gnt_mem = mem_valid & (~alu_valid | ~last_mem_q);

  assign full      = (cnt_q == FULL);
  assign alu_ready = gnt_alu & ~full;
  assign mem_ready = gnt_mem & ~full;

  assign acc     = alu_ready | mem_ready;
  assign in_rd   = gnt_alu ? alu_rd : mem_rd;
  assign in_data = gnt_alu ? alu_data : mem_data;
  assign push    = acc & (in_rd != 5'd0);
  assign pop     = (cnt_q != '0) & ~wb_stall;
  assign cnt_d   = cnt_q + PW'(push) - PW'(pop);

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      last_mem_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      if (acc)  last_mem_q <= mem_ready;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      rd_q[wp_q]  <= in_rd;
      dat_q[wp_q] <= in_data;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      we_q <= 1'b0;
      wr_q <= '0;
      d_q  <= '0;
    end else begin
      we_q <= pop;
      if (pop) begin
        wr_q <= rd_q[rp_q];
        d_q  <= dat_q[rp_q];
      end
    end
  end

  assign We       = we_q;
  assign Wr       = wr_q;
  assign D        = d_q;
  assign pend_cnt = cnt_q;

`ifdef WB_BYPASS_EN
  logic          fa, fb;
  logic [31:0]   fqa, fqb;
  logic [AW-1:0] idx;

  // Scan oldest to youngest so the youngest match overwrites older ones
  always_comb begin
    fa  = 1'b0;
    fb  = 1'b0;
    fqa = '0;
    fqb = '0;
    idx = '0;
    if (we_q && Ra != 5'd0 && wr_q == Ra) begin
      fa  = 1'b1;
      fqa = d_q;
    end
    if (we_q && Rb != 5'd0 && wr_q == Rb) begin
      fb  = 1'b1;
      fqb = d_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rp_q + AW'(i);
      if (PW'(i) < cnt_q) begin
        if (Ra != 5'd0 && rd_q[idx] == Ra) begin
          fa  = 1'b1;
          fqa = dat_q[idx];
        end
        if (Rb != 5'd0 && rd_q[idx] == Rb) begin
          fb  = 1'b1;
          fqb = dat_q[idx];
        end
      end
    end
  end

  assign Fa  = fa;
  assign Fb  = fb;
  assign FQa = fqa;
  assign FQb = fqb;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{Ra, Rb};
  assign Fa  = 1'b0;
  assign Fb  = 1'b0;
  assign FQa = '0;
  assign FQb = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: queue-based reference model plus directed scenarios.
module tb_regfile_wb_ctrl;
  localparam int DEPTH = 4;
  localparam int PW    = 3;

  logic          Clk = 1'b0;
  logic          Clrn = 1'b0;
  logic          alu_valid = 1'b0, mem_valid = 1'b0;
  logic          alu_ready, mem_ready;
  logic [4:0]    alu_rd = '0, mem_rd = '0;
  logic [31:0]   alu_data = '0, mem_data = '0;
  logic          wb_stall = 1'b0;
  logic [4:0]    Wr;
  logic [31:0]   D;
  logic          We;
  logic [PW-1:0] pend_cnt;
  logic [4:0]    Ra = '0, Rb = '0;
  logic          Fa, Fb;
  logic [31:0]   FQa, FQb;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  regfile_wb_ctrl #(.DEPTH(DEPTH), .PW(PW)) dut (
    .Clk(Clk), .Clrn(Clrn),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_stall(wb_stall),
    .Wr(Wr), .D(D), .We(We), .pend_cnt(pend_cnt),
    .Ra(Ra), .Rb(Rb), .Fa(Fa), .Fb(Fb), .FQa(FQa), .FQb(FQb)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_wr = '0;
  logic [31:0] m_d = '0;
  bit          m_last_mem = 1'b1;

  function automatic bit m_gnt_alu();
    if (alu_valid && mem_valid) return m_last_mem;
    return alu_valid;
  endfunction

  function automatic bit m_gnt_mem();
    if (alu_valid && mem_valid) return !m_last_mem;
    return mem_valid;
  endfunction

  function automatic logic [32:0] m_fwd(input logic [4:0] a);
`ifdef WB_BYPASS_EN
    if (a == 5'd0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].rd == a) return {1'b1, mq[i].d};
    if (m_we && m_wr == a) return {1'b1, m_d};
`endif
    return '0;
  endfunction

  always @(negedge Clrn) begin
    mq.delete();
    m_we = 1'b0;
    m_wr = '0;
    m_d = '0;
    m_last_mem = 1'b1;
  end

  always @(posedge Clk) begin
    if (Clrn) begin
      bit ra, rm;
      ent_t e;
      ra = m_gnt_alu() && (mq.size() < DEPTH);
      rm = m_gnt_mem() && (mq.size() < DEPTH);
      if (mq.size() != 0 && !wb_stall) begin
        e = mq.pop_front();
        m_we = 1'b1;
        m_wr = e.rd;
        m_d = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (ra || rm) begin
        m_last_mem = rm;
        e.rd = ra ? alu_rd : mem_rd;
        e.d  = ra ? alu_data : mem_data;
        if (e.rd != 5'd0) mq.push_back(e);
      end
    end
  end

  always @(negedge Clk) begin
    if (Clrn) begin
      logic [32:0] fa, fb;
      fa = m_fwd(Ra);
      fb = m_fwd(Rb);
      chk("m_alu_ready", alu_ready, m_gnt_alu() && mq.size() < DEPTH);
      chk("m_mem_ready", mem_ready, m_gnt_mem() && mq.size() < DEPTH);
      chk("m_We", We, m_we);
      chk("m_Wr", Wr, m_wr);
      chk("m_D", D, m_d);
      chk("m_pend_cnt", pend_cnt, mq.size());
      chk("m_Fa", Fa, fa[32]);
      chk("m_FQa", FQa, fa[31:0]);
      chk("m_Fb", Fb, fb[32]);
      chk("m_FQb", FQb, fb[31:0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [4:0] wrs[$];
    logic [3:0] gseq;
    int maxc;
    int r;

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_We", We, 0);
    chk("rst_Wr", Wr, 0);
    chk("rst_D", D, 0);
    chk("rst_cnt", pend_cnt, 0);
    chk("rst_Fa", Fa, 0);
    chk("rst_FQa", FQa, 0);
    Clrn = 1'b1;

    // Both sources valid every cycle
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    mem_valid = 1; mem_rd = 2; mem_data = 32'h22;
    maxc = 0;
    gseq = '0;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) begin
        alu_valid = 0;
        mem_valid = 0;
      end
      #1;
      if (i < 4) begin
        gseq[i] = mem_ready;
        chk("alt_onehot", alu_ready ^ mem_ready, 1);
      end
      if (int'(pend_cnt) > maxc) maxc = pend_cnt;
      step();
      if (We) wrs.push_back(Wr);
      if (int'(pend_cnt) > maxc) maxc = pend_cnt;
    end
    chk("alt_grants", gseq, 4'b1010);
    chk("alt_maxcnt", maxc, 1);
    chk("alt_nwr", wrs.size(), 4);
    for (int i = 0; i < wrs.size() && i < 4; i++)
      chk("alt_wr", wrs[i], (i % 2 == 0) ? 1 : 2);

    // Single ALU write
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1;
    chk("single_ready", alu_ready, 1);
    step();
    alu_valid = 0;
    step();
    chk("single_We", We, 1);
    chk("single_Wr", Wr, 5);
    chk("single_D", D, 32'hDEADBEEF);
    step();
    chk("single_We_off", We, 0);

    // Stall fill then drain
    wb_stall = 1; alu_valid = 1;
    r = 3;
    for (int i = 0; i < 6; i++) begin
      alu_rd = 5'(r);
      alu_data = 32'h300 + r;
      #1;
      if (alu_ready) r++;
      step();
    end
    #1;
    chk("stall_cnt", pend_cnt, 4);
    chk("stall_ready", alu_ready, 0);
    alu_valid = 0;
    wb_stall = 0;
    wrs.delete();
    for (int i = 0; i < 6; i++) begin
      step();
      if (We) wrs.push_back(Wr);
    end
    chk("drain_nwr", wrs.size(), 4);
    for (int i = 0; i < wrs.size() && i < 4; i++)
      chk("drain_wr", wrs[i], 3 + i);

    // rd=0 discarded
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
    #1;
    chk("rd0_ready", alu_ready, 1);
    step();
    alu_valid = 0;
    chk("rd0_cnt", pend_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rd0_We", We, 0);
    end

    // Forwarding lookup with two queued writes to x7
    wb_stall = 1;
    alu_valid = 1; alu_rd = 7; alu_data = 32'hA;
    step();
    alu_data = 32'hB;
    step();
    alu_valid = 0;
    Ra = 7; Rb = 7;
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_Fa", Fa, 1);
    chk("byp_FQa", FQa, 32'hB);
    chk("byp_Fb", Fb, 1);
`else
    chk("byp_Fa", Fa, 0);
    chk("byp_FQa", FQa, 0);
    chk("byp_Fb", Fb, 0);
`endif
    Ra = 0;
    #1;
    chk("byp_Ra0", Fa, 0);
    wb_stall = 0;
    repeat (2) step();
    Rb = 0;
    repeat (2) step();

    // Asynchronous reset with queued entries and a write in flight
    wb_stall = 1; alu_valid = 1;
    for (int i = 0; i < 4; i++) begin
      alu_rd = 5'(8 + i);
      alu_data = 32'h800 + i;
      step();
    end
    alu_valid = 0;
    wb_stall = 0;
    step();
    chk("prerst_We", We, 1);
    chk("prerst_cnt", pend_cnt, 3);
    Clrn = 0;
    #1;
    chk("arst_We", We, 0);
    chk("arst_cnt", pend_cnt, 0);
    #1;
    Clrn = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("postrst_We", We, 0);
    end
    alu_valid = 1; alu_rd = 1;
    mem_valid = 1; mem_rd = 2;
    #1;
    chk("postrst_alu", alu_ready, 1);
    chk("postrst_mem", mem_ready, 0);
    step();
    alu_valid = 0;
    mem_valid = 0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
